// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_arbiter
//  Purpose  : Owns the register file write port. Round-robin arbitration of
//             writeback requests from the ALU, the load return path and the
//             CSR unit, with per-source width/sign handling, plus a
//             pending-load scoreboard used by decode for hazard stalls.
//  Ports    : clk, rst                      - clock, sync active-high reset
//             alu_valid/ready/rd/data/word  - ALU writeback request
//             ld_valid/ready/rd/data/size/unsigned - load return request
//             csr_valid/ready/rd/data       - CSR writeback request
//             ld_issue/ld_issue_rd/ld_issue_ready - load issue (sets busy)
//             id_rs1/id_rs2/id_hazard       - decode hazard query
//             busy_mask                     - registered scoreboard
//             rf_wen/rf_waddr/rf_wdata      - registered RF write port
//  Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int XLEN = 64,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            alu_word,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic            csr_valid,
    output logic            csr_ready,
    input  logic [AW-1:0]   csr_rd,
    input  logic [XLEN-1:0] csr_data,
    input  logic            ld_issue,
    input  logic [AW-1:0]   ld_issue_rd,
    output logic            ld_issue_ready,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    output logic            id_hazard,
    output logic [NREG-1:0] busy_mask,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    // Round-robin pointer encoding: identifies the source granted last.
    localparam logic [1:0] c_SRC_ALU = 2'd0;
    localparam logic [1:0] c_SRC_LD  = 2'd1;
    localparam logic [1:0] c_SRC_CSR = 2'd2;

    logic [1:0]      r_last_grant;
    logic [1:0]      w_last_grant_nxt;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            r_wb_is_ld;

    logic            w_alu_elig;
    logic            w_gnt_alu;
    logic            w_gnt_ld;
    logic            w_gnt_csr;
    logic            w_gnt_any;
    logic            w_ld_set;
    logic [AW-1:0]   w_wb_rd;
    logic [XLEN-1:0] w_wb_data;
    logic [XLEN-1:0] w_alu_ext;
    logic [XLEN-1:0] w_ld_ext;

    // An ALU write to a register with a load still in flight would be
    // overwritten out of order by the load return, so hold it off.
    assign w_alu_elig = alu_valid && !(r_busy[alu_rd] && (alu_rd != '0));

    // ------------------------------------------------------------------
    // Pointer register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= c_SRC_CSR;
        end else begin
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Pointer next state: moves only when a handshake completes.
    always_comb begin
        w_last_grant_nxt = r_last_grant;
        if (w_gnt_alu) begin
            w_last_grant_nxt = c_SRC_ALU;
        end else if (w_gnt_ld) begin
            w_last_grant_nxt = c_SRC_LD;
        end else if (w_gnt_csr) begin
            w_last_grant_nxt = c_SRC_CSR;
        end
    end

    // Grant decode: search starts with the source after the last winner.
    always_comb begin
        w_gnt_alu = 1'b0;
        w_gnt_ld  = 1'b0;
        w_gnt_csr = 1'b0;
        case (r_last_grant)
            c_SRC_ALU: begin
                if (ld_valid)        w_gnt_ld  = 1'b1;
                else if (csr_valid)  w_gnt_csr = 1'b1;
                else if (w_alu_elig) w_gnt_alu = 1'b1;
            end
            c_SRC_LD: begin
                if (csr_valid)       w_gnt_csr = 1'b1;
                else if (w_alu_elig) w_gnt_alu = 1'b1;
                else if (ld_valid)   w_gnt_ld  = 1'b1;
            end
            default: begin
                if (w_alu_elig)      w_gnt_alu = 1'b1;
                else if (ld_valid)   w_gnt_ld  = 1'b1;
                else if (csr_valid)  w_gnt_csr = 1'b1;
            end
        endcase
    end

    assign w_gnt_any = w_gnt_alu | w_gnt_ld | w_gnt_csr;
    assign alu_ready = w_gnt_alu;
    assign ld_ready  = w_gnt_ld;
    assign csr_ready = w_gnt_csr;

    // ------------------------------------------------------------------
    // Writeback data shaping
    // ------------------------------------------------------------------
    assign w_alu_ext = alu_word ? {{(XLEN-32){alu_data[31]}}, alu_data[31:0]}
                                : alu_data;

    always_comb begin
        w_ld_ext = ld_data;
        case (ld_size)
            2'd0:    w_ld_ext = {{(XLEN-8){ld_data[7] & ~ld_unsigned}},   ld_data[7:0]};
            2'd1:    w_ld_ext = {{(XLEN-16){ld_data[15] & ~ld_unsigned}}, ld_data[15:0]};
            2'd2:    w_ld_ext = {{(XLEN-32){ld_data[31] & ~ld_unsigned}}, ld_data[31:0]};
            default: w_ld_ext = ld_data;
        endcase
    end

    always_comb begin
        w_wb_rd   = csr_rd;
        w_wb_data = csr_data;
        if (w_gnt_alu) begin
            w_wb_rd   = alu_rd;
            w_wb_data = w_alu_ext;
        end else if (w_gnt_ld) begin
            w_wb_rd   = ld_rd;
            w_wb_data = w_ld_ext;
        end
    end

    // Registered write port. A grant to x0 still completes the handshake
    // but never raises the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            r_wb_is_ld <= 1'b0;
        end else begin
            rf_wen     <= w_gnt_any && (w_wb_rd != '0);
            r_wb_is_ld <= w_gnt_ld;
            if (w_gnt_any) begin
                rf_waddr <= w_wb_rd;
                rf_wdata <= w_wb_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending-load scoreboard
    // ------------------------------------------------------------------
    assign ld_issue_ready = !r_busy[ld_issue_rd];
    assign w_ld_set       = ld_issue && ld_issue_ready && (ld_issue_rd != '0);

    // The clear is applied first so that a new issue to the same register
    // on the same edge leaves the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (rf_wen && r_wb_is_ld) begin
            w_busy_nxt[rf_waddr] = 1'b0;
        end
        if (w_ld_set) begin
            w_busy_nxt[ld_issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_mask = r_busy;
    assign id_hazard = ((id_rs1 != '0) && r_busy[id_rs1]) ||
                       ((id_rs2 != '0) && r_busy[id_rs2]);

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_wb_arbiter
//  Purpose  : Self-checking bench for rf_wb_arbiter: vector table for the
//             data rules, directed multi-cycle sequences, and randomized
//             traffic against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;
    localparam int XLEN = 64;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid, alu_ready, alu_word;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid, ld_ready, ld_unsigned;
    logic [AW-1:0]   ld_rd;
    logic [XLEN-1:0] ld_data;
    logic [1:0]      ld_size;
    logic            csr_valid, csr_ready;
    logic [AW-1:0]   csr_rd;
    logic [XLEN-1:0] csr_data;
    logic            ld_issue, ld_issue_ready;
    logic [AW-1:0]   ld_issue_rd;
    logic [AW-1:0]   id_rs1, id_rs2;
    logic            id_hazard;
    logic [NREG-1:0] busy_mask;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.XLEN(XLEN), .AW(AW), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
        .alu_data(alu_data), .alu_word(alu_word),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
        .ld_data(ld_data), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_rd(csr_rd),
        .csr_data(csr_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_hazard(id_hazard),
        .busy_mask(busy_mask),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    // Requester rule: a request not accepted must be held unchanged.
    logic            p_alu = 1'b0, p_ld = 1'b0, p_csr = 1'b0;
    logic [AW-1:0]   s_alu_rd, s_ld_rd, s_csr_rd;
    logic [XLEN-1:0] s_alu_data, s_ld_data, s_csr_data;
    logic            s_alu_word, s_ld_uns;
    logic [1:0]      s_ld_size;

    always @(negedge clk) begin
        if (!rst) begin
            if (p_alu) assert (alu_valid && alu_rd == s_alu_rd && alu_data == s_alu_data && alu_word == s_alu_word)
                else $error("FAIL requester_rule_alu valid=%0b required held request", alu_valid);
            if (p_ld) assert (ld_valid && ld_rd == s_ld_rd && ld_data == s_ld_data && ld_size == s_ld_size && ld_unsigned == s_ld_uns)
                else $error("FAIL requester_rule_ld valid=%0b required held request", ld_valid);
            if (p_csr) assert (csr_valid && csr_rd == s_csr_rd && csr_data == s_csr_data)
                else $error("FAIL requester_rule_csr valid=%0b required held request", csr_valid);
        end
        p_alu      <= alu_valid && !alu_ready && !rst;
        p_ld       <= ld_valid && !ld_ready && !rst;
        p_csr      <= csr_valid && !csr_ready && !rst;
        s_alu_rd   <= alu_rd;   s_alu_data <= alu_data; s_alu_word <= alu_word;
        s_ld_rd    <= ld_rd;    s_ld_data  <= ld_data;  s_ld_size  <= ld_size;
        s_ld_uns   <= ld_unsigned;
        s_csr_rd   <= csr_rd;   s_csr_data <= csr_data;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0; alu_word = 1'b0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0; ld_size = 2'd0; ld_unsigned = 1'b0;
        csr_valid = 1'b0; csr_rd = '0; csr_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0; id_rs1 = '0; id_rs2 = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Reference: load extension from the width/sign rules.
    function automatic logic [63:0] ld_ext(input logic [63:0] d, input logic [1:0] sz, input logic u);
        int          bits;
        logic [63:0] mask;
        logic [63:0] v;
        bits = 8 << sz;
        mask = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
        v    = d & mask;
        if (!u && bits < 64 && d[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // Reference model state
    logic [31:0] m_busy;
    int          m_last;   // 0=ALU 1=LD 2=CSR
    logic        m_wen, m_wis_ld;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata;

    task automatic model_check(output logic [2:0] acc_o);
        logic [2:0]  elig;
        int          g;
        logic [63:0] val;
        logic [4:0]  rd;
        logic [31:0] nb;
        elig[0] = alu_valid && !(alu_rd != 0 && m_busy[alu_rd]);
        elig[1] = ld_valid;
        elig[2] = csr_valid;
        g = -1;
        for (int k = 1; k <= 3; k++) begin
            int s;
            s = (m_last + k) % 3;
            if (g < 0 && elig[s]) g = s;
        end
        chk("rnd_wen", rf_wen, m_wen);
        if (m_wen) begin
            chk("rnd_waddr", rf_waddr, m_waddr);
            chk("rnd_wdata", rf_wdata, m_wdata);
        end
        chk("rnd_busy", busy_mask, m_busy);
        chk("rnd_ready", {csr_ready, ld_ready, alu_ready}, (g < 0) ? 3'b000 : 3'(1 << g));
        chk("rnd_issue_ready", ld_issue_ready, !m_busy[ld_issue_rd]);
        chk("rnd_hazard", id_hazard, (id_rs1 != 0 && m_busy[id_rs1]) || (id_rs2 != 0 && m_busy[id_rs2]));
        nb = m_busy;
        if (m_wen && m_wis_ld) nb[m_waddr] = 1'b0;
        if (ld_issue && !m_busy[ld_issue_rd] && ld_issue_rd != 0) nb[ld_issue_rd] = 1'b1;
        nb[0]  = 1'b0;
        m_busy = nb;
        acc_o  = (g < 0) ? 3'b000 : 3'(1 << g);
        if (g >= 0) begin
            m_last = g;
            case (g)
                0:       begin rd = alu_rd; val = alu_word ? 64'($signed(alu_data[31:0])) : alu_data; end
                1:       begin rd = ld_rd;  val = ld_ext(ld_data, ld_size, ld_unsigned); end
                default: begin rd = csr_rd; val = csr_data; end
            endcase
            m_wen    = (rd != 0);
            m_waddr  = rd;
            m_wdata  = val;
            m_wis_ld = (g == 1);
        end else begin
            m_wen    = 1'b0;
            m_wis_ld = 1'b0;
        end
    endtask

    typedef struct {
        int          src;     // 0=ALU 1=LD 2=CSR
        logic [4:0]  rd;
        logic [63:0] data;
        logic        word;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs[12];
    logic [2:0]  rr_exp  [6];
    logic [4:0]  rr_addr [6];
    logic [63:0] rr_data [6];
    logic [2:0]  acc;

    initial begin
        vecs[0]  = '{0, 5'd5,  64'h0000_0001_8000_0000, 1'b1, 2'd0, 1'b0, 64'hFFFF_FFFF_8000_0000};
        vecs[1]  = '{0, 5'd6,  64'h0000_0001_8000_0000, 1'b0, 2'd0, 1'b0, 64'h0000_0001_8000_0000};
        vecs[2]  = '{0, 5'd8,  64'hFFFF_FFFF_7FFF_FFFF, 1'b1, 2'd0, 1'b0, 64'h0000_0000_7FFF_FFFF};
        vecs[3]  = '{1, 5'd10, 64'h0000_0000_0000_80F0, 1'b0, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_80F0};
        vecs[4]  = '{1, 5'd11, 64'h0000_0000_0000_80F0, 1'b0, 2'd1, 1'b1, 64'h0000_0000_0000_80F0};
        vecs[5]  = '{1, 5'd12, 64'h0000_0000_0000_80F0, 1'b0, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0};
        vecs[6]  = '{1, 5'd13, 64'h0000_0000_0000_80F0, 1'b0, 2'd0, 1'b1, 64'h0000_0000_0000_00F0};
        vecs[7]  = '{1, 5'd14, 64'h1234_5678_8000_0001, 1'b0, 2'd2, 1'b0, 64'hFFFF_FFFF_8000_0001};
        vecs[8]  = '{1, 5'd15, 64'h1234_5678_8000_0001, 1'b0, 2'd2, 1'b1, 64'h0000_0000_8000_0001};
        vecs[9]  = '{1, 5'd16, 64'h8000_0000_0000_0001, 1'b0, 2'd3, 1'b1, 64'h8000_0000_0000_0001};
        vecs[10] = '{2, 5'd31, 64'hDEAD_BEEF_0123_4567, 1'b0, 2'd0, 1'b0, 64'hDEAD_BEEF_0123_4567};
        vecs[11] = '{1, 5'd17, 64'hFFFF_FFFF_FFFF_FF7F, 1'b0, 2'd0, 1'b0, 64'h0000_0000_0000_007F};
        rr_exp  = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
        rr_addr = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
        rr_data = '{64'h11, 64'h22, 64'h33, 64'h11, 64'h22, 64'h33};

        // ---------------- reset state ----------------
        do_reset();
        @(negedge clk);
        chk("reset_wen", rf_wen, 1'b0);
        chk("reset_waddr", rf_waddr, 5'd0);
        chk("reset_wdata", rf_wdata, 64'd0);
        chk("reset_busy", busy_mask, 32'd0);
        chk("reset_readies", {alu_ready, ld_ready, csr_ready}, 3'b000);
        next_cycle();

        // ---------------- data rule vectors ----------------
        for (int i = 0; i < 12; i++) begin
            idle();
            case (vecs[i].src)
                0: begin alu_valid = 1'b1; alu_rd = vecs[i].rd; alu_data = vecs[i].data; alu_word = vecs[i].word; end
                1: begin ld_valid = 1'b1; ld_rd = vecs[i].rd; ld_data = vecs[i].data;
                         ld_size = vecs[i].size; ld_unsigned = vecs[i].uns; end
                default: begin csr_valid = 1'b1; csr_rd = vecs[i].rd; csr_data = vecs[i].data; end
            endcase
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), {alu_ready, ld_ready, csr_ready}, 3'b100 >> vecs[i].src);
            next_cycle();
            idle();
            @(negedge clk);
            chk($sformatf("vec%0d_wen", i), rf_wen, 1'b1);
            chk($sformatf("vec%0d_waddr", i), rf_waddr, vecs[i].rd);
            chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].exp);
            next_cycle();
        end

        // ---------------- round robin, back-to-back ----------------
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11; alu_word = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 64'h22; ld_size = 2'd3; ld_unsigned = 1'b0;
        csr_valid = 1'b1; csr_rd = 5'd3; csr_data = 64'h33;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_ready", k), {alu_ready, ld_ready, csr_ready}, rr_exp[k]);
            if (k > 0) begin
                chk($sformatf("rr%0d_wen", k), rf_wen, 1'b1);
                chk($sformatf("rr%0d_waddr", k), rf_waddr, rr_addr[k-1]);
                chk($sformatf("rr%0d_wdata", k), rf_wdata, rr_data[k-1]);
            end
            next_cycle();
            if (k == 3) alu_valid = 1'b0;
            if (k == 4) ld_valid = 1'b0;
            if (k == 5) csr_valid = 1'b0;
        end
        @(negedge clk);
        chk("rr_last_wen", rf_wen, 1'b1);
        chk("rr_last_waddr", rf_waddr, 5'd3);
        next_cycle();
        @(negedge clk);
        chk("rr_idle_wen", rf_wen, 1'b0);
        next_cycle();

        // ---------------- scoreboard ----------------
        do_reset();
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        @(negedge clk);
        chk("sb_issue_ready", ld_issue_ready, 1'b1);
        next_cycle();
        id_rs1 = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'hA5; alu_word = 1'b0;
        @(negedge clk);
        chk("sb_busy_set", busy_mask, 32'h0000_0080);
        chk("sb_hazard", id_hazard, 1'b1);
        chk("sb_alu_blocked", {alu_ready, ld_ready, csr_ready}, 3'b000);
        chk("sb_reissue_blocked", ld_issue_ready, 1'b0);
        next_cycle();
        ld_issue = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 64'h77; ld_size = 2'd3; ld_unsigned = 1'b0;
        @(negedge clk);
        chk("sb_ld_grant", {alu_ready, ld_ready, csr_ready}, 3'b010);
        next_cycle();
        ld_valid = 1'b0;
        @(negedge clk);
        chk("sb_ld_wen", rf_wen, 1'b1);
        chk("sb_ld_waddr", rf_waddr, 5'd7);
        chk("sb_ld_wdata", rf_wdata, 64'h77);
        chk("sb_busy_during_wen", busy_mask, 32'h0000_0080);
        chk("sb_alu_still_blocked", alu_ready, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("sb_busy_cleared", busy_mask, 32'd0);
        chk("sb_hazard_cleared", id_hazard, 1'b0);
        chk("sb_alu_released", alu_ready, 1'b1);
        next_cycle();
        alu_valid = 1'b0; id_rs1 = '0;
        @(negedge clk);
        chk("sb_alu_wen", rf_wen, 1'b1);
        chk("sb_alu_waddr", rf_waddr, 5'd7);
        chk("sb_alu_wdata", rf_wdata, 64'hA5);
        next_cycle();

        // ---------------- same-edge set/clear race ----------------
        do_reset();
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'h99; ld_size = 2'd3;
        @(negedge clk);
        chk("race_ld_ready", ld_ready, 1'b1);
        next_cycle();
        ld_valid = 1'b0; ld_issue = 1'b1; ld_issue_rd = 5'd9;
        @(negedge clk);
        chk("race_wen", rf_wen, 1'b1);
        chk("race_waddr", rf_waddr, 5'd9);
        chk("race_issue_ready", ld_issue_ready, 1'b1);
        next_cycle();
        ld_issue = 1'b0;
        @(negedge clk);
        chk("race_busy_kept", busy_mask, 32'h0000_0200);
        next_cycle();

        // ---------------- x0 grant, then mid-operation reset ----------------
        csr_valid = 1'b1; csr_rd = 5'd0; csr_data = 64'hCC;
        @(negedge clk);
        chk("x0_csr_ready", {alu_ready, ld_ready, csr_ready}, 3'b001);
        next_cycle();
        csr_valid = 1'b0;
        @(negedge clk);
        chk("x0_no_wen", rf_wen, 1'b0);
        next_cycle();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h44;
        @(negedge clk);
        chk("mrst_alu_ready", alu_ready, 1'b1);
        next_cycle();
        alu_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mrst_pending_wen", rf_wen, 1'b1);
        next_cycle();
        rst = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h1;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 64'h0; ld_size = 2'd3;
        @(negedge clk);
        chk("mrst_wen_dropped", rf_wen, 1'b0);
        chk("mrst_busy_cleared", busy_mask, 32'd0);
        chk("mrst_ptr_reset", {alu_ready, ld_ready, csr_ready}, 3'b100);
        next_cycle();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("mrst_ld_next", {alu_ready, ld_ready, csr_ready}, 3'b010);
        next_cycle();
        ld_valid = 1'b0;

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        m_busy = '0; m_last = 2; m_wen = 1'b0; m_wis_ld = 1'b0; m_waddr = '0; m_wdata = '0;
        acc = 3'b000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!alu_valid || acc[0]) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = {$urandom, $urandom};
                alu_word  = 1'($urandom_range(0, 1));
            end
            if (!ld_valid || acc[1]) begin
                ld_valid    = ($urandom_range(0, 2) != 0);
                ld_rd       = 5'($urandom_range(0, 7));
                ld_data     = {$urandom, $urandom};
                ld_size     = 2'($urandom_range(0, 3));
                ld_unsigned = 1'($urandom_range(0, 1));
            end
            if (!csr_valid || acc[2]) begin
                csr_valid = ($urandom_range(0, 3) == 0);
                csr_rd    = 5'($urandom_range(0, 7));
                csr_data  = {$urandom, $urandom};
            end
            ld_issue    = ($urandom_range(0, 2) == 0);
            ld_issue_rd = 5'($urandom_range(0, 7));
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            @(negedge clk);
            model_check(acc);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
